// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor: PE state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package coproc_pkg;

    localparam int PE_DATA_W = 32;
    localparam int PE_ADDR_W = 16;
    localparam int PE_IDX_W  = 8;

    // Encoding is shared with the main control unit, which decodes PE status.
    typedef enum logic [2:0] {
        PE_IDLE = 3'd0,
        PE_REQ  = 3'd1,
        PE_RD_A = 3'd2,
        PE_RD_B = 3'd3,
        PE_ACC  = 3'd4,
        PE_WR   = 3'd5,
        PE_DONE = 3'd6
    } pe_state_t;

    // The PE owns (or is asking for) the memory bus from REQ through WR.
    function automatic logic pe_wants_bus(input pe_state_t s);
        return (s == PE_REQ) || (s == PE_RD_A) || (s == PE_RD_B) ||
               (s == PE_ACC) || (s == PE_WR);
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Signed multiply-accumulate for one C element; acc is 2*DATA_W wide, result is acc narrowed to DATA_W.
// Latency: one cycle per accumulate; result is combinational from the accumulator.
// Backpressure: none internally; the caller only pulses load_a/acc_en on granted cycles.
// Build option: PROCESSING_ELEMENT_SATURATE_EN clamps the result to the signed DATA_W range instead of truncating.
module pe_mac #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_a,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

`ifdef PROCESSING_ELEMENT_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic signed [DATA_W-1:0]   a_q;
    logic signed [2*DATA_W-1:0] acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic        [DATA_W:0]     acc_top;
    logic                       overflow;

    assign prod     = (2*DATA_W)'(a_q) * (2*DATA_W)'($signed(operand));
    // Fits in DATA_W signed only if the top DATA_W+1 bits are all equal.
    assign acc_top  = acc_q[2*DATA_W-1:DATA_W-1];
    assign overflow = !((&acc_top) || (~|acc_top));

    // Operand a and the accumulator; clear wins over any update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            acc_q <= '0;
        end else if (clr) begin
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            if (load_a) a_q   <= $signed(operand);
            if (acc_en) acc_q <= acc_q + prod;
        end
    end

    // Narrow the accumulator: clamp on overflow when saturating, else keep low bits.
    always_comb begin
        result = acc_q[DATA_W-1:0];
        if (SATURATE && overflow)
            result = acc_q[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
    end

endmodule

// File: rtl/processing_element.sv
// Computes one C[row][col] = sum_k A[row][k]*B[k][col] over a shared memory bus and writes it back.
// Latency: 3N+3 cycles from index accept to o_Result_Ready with the grant held continuously.
// Backpressure: any cycle without i_Grant in RD_A/RD_B/ACC/WR stalls in place; build option PROCESSING_ELEMENT_SATURATE_EN (see pe_mac).
module processing_element
    import coproc_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ADDR_W = PE_ADDR_W,
    parameter int IDX_W  = PE_IDX_W
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Indexes_Ready,
    input  logic [IDX_W-1:0]  i_Row_Index,
    input  logic [IDX_W-1:0]  i_Column_Index,
    output logic              o_Indexes_Received,
    input  logic [IDX_W-1:0]  i_Dim,
    input  logic [ADDR_W-1:0] i_A_Base,
    input  logic [ADDR_W-1:0] i_B_Base,
    input  logic [ADDR_W-1:0] i_C_Base,
    output logic              o_Grant_Request,
    input  logic              i_Grant,
    output logic [ADDR_W-1:0] o_Memory_Address,
    output logic              o_Mem_Read,
    output logic              o_Mem_Write,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    output logic              o_Result_Ready,
    output logic              o_Busy
);

    pe_state_t         state_q, state_d;
    logic [IDX_W-1:0]  k_q, row_q, col_q, dim_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mac_result;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic              accept, clr, load_a, acc_en, k_inc, last_k;

    // Read data is only valid the cycle after a strobe; hold it so a stall
    // in RD_B or ACC still consumes the right word when the grant returns.
    assign rd_data = rd_pend_q ? i_Mem_Rdata : hold_q;
    assign last_k  = (k_q == dim_q - IDX_W'(1));

    // Address generation, all modulo 2^ADDR_W.
    assign a_addr = i_A_Base + ADDR_W'(row_q) * ADDR_W'(dim_q) + ADDR_W'(k_q);
    assign b_addr = i_B_Base + ADDR_W'(k_q) * ADDR_W'(dim_q) + ADDR_W'(col_q);
    assign c_addr = i_C_Base + ADDR_W'(row_q) * ADDR_W'(dim_q) + ADDR_W'(col_q);

    // State, latched indexes, k counter and read-data capture.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= PE_IDLE;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dim_q     <= '0;
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= o_Mem_Read;
            if (rd_pend_q) hold_q <= i_Mem_Rdata;
            if (accept) begin
                row_q <= i_Row_Index;
                col_q <= i_Column_Index;
                dim_q <= i_Dim;
                k_q   <= '0;
            end else if (k_inc) begin
                k_q <= k_q + IDX_W'(1);
            end
        end
    end

    // Next state, bus strobes and datapath controls.
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        clr                = 1'b0;
        load_a             = 1'b0;
        acc_en             = 1'b0;
        k_inc              = 1'b0;
        o_Indexes_Received = 1'b0;
        o_Memory_Address   = '0;
        o_Mem_Read         = 1'b0;
        o_Mem_Write        = 1'b0;
        o_Mem_Wdata        = '0;
        o_Result_Ready     = 1'b0;
        o_Grant_Request    = pe_wants_bus(state_q);
        o_Busy             = (state_q != PE_IDLE);
        case (state_q)
            PE_IDLE: if (i_Indexes_Ready) begin
                accept             = 1'b1;
                clr                = 1'b1;
                o_Indexes_Received = 1'b1;
                state_d            = PE_REQ;
            end
            PE_REQ: if (i_Grant) state_d = (dim_q == '0) ? PE_WR : PE_RD_A;
            PE_RD_A: if (i_Grant) begin
                o_Memory_Address = a_addr;
                o_Mem_Read       = 1'b1;
                state_d          = PE_RD_B;
            end
            PE_RD_B: if (i_Grant) begin
                o_Memory_Address = b_addr;
                o_Mem_Read       = 1'b1;
                load_a           = 1'b1;
                state_d          = PE_ACC;
            end
            PE_ACC: if (i_Grant) begin
                acc_en = 1'b1;
                if (last_k) begin
                    state_d = PE_WR;
                end else begin
                    k_inc   = 1'b1;
                    state_d = PE_RD_A;
                end
            end
            PE_WR: if (i_Grant) begin
                o_Memory_Address = c_addr;
                o_Mem_Write      = 1'b1;
                o_Mem_Wdata      = mac_result;
                state_d          = PE_DONE;
            end
            PE_DONE: begin
                o_Result_Ready = 1'b1;
                state_d        = PE_IDLE;
            end
            default: state_d = PE_IDLE;
        endcase
    end

    pe_mac #(.DATA_W(DATA_W)) u_mac (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .clr     (clr),
        .load_a  (load_a),
        .acc_en  (acc_en),
        .operand (rd_data),
        .result  (mac_result)
    );

endmodule

// File: doc/processing_element.md
PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 Parameter DATA_W, default 32: signed element width.
REQ-002 Parameter ADDR_W, default 16: memory word-address width.
REQ-003 Parameter IDX_W, default 8: row/column index and dimension width.
REQ-004 i_Clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_Reset  in  1  asynchronous, active-high reset.
REQ-006 i_Indexes_Ready  in  1  level; the main control unit has a valid index pair.
REQ-007 i_Row_Index / i_Column_Index  in  IDX_W each  block row/column to compute.
REQ-008 o_Indexes_Received  out  1  one-cycle pulse when the indexes are latched.
REQ-009 i_Dim  in  IDX_W  matrix dimension N, static while busy.
REQ-010 i_A_Base / i_B_Base / i_C_Base  in  ADDR_W each  matrix base addresses, static while busy.
REQ-011 o_Grant_Request  out  1  memory bus request; i_Grant  in  1  bus granted.
REQ-012 o_Memory_Address  out  ADDR_W; o_Mem_Read / o_Mem_Write  out  1 each.
REQ-013 o_Mem_Wdata  out  DATA_W; i_Mem_Rdata  in  DATA_W, valid one cycle after o_Mem_Read.
REQ-014 o_Result_Ready  out  1  one-cycle pulse after C written; o_Busy  out  1  high outside IDLE.

Function
REQ-015 States: IDLE, REQ, RD_A, RD_B, ACC, WR, DONE.
REQ-016 IDLE with i_Indexes_Ready=1: latch row, column and N; pulse o_Indexes_Received; clear k and the accumulator; go to REQ.
REQ-017 o_Grant_Request is high in REQ through WR inclusive and low in all other states.
REQ-018 REQ: on i_Grant=1, go to RD_A, or to WR if N=0.
REQ-019 RD_A: address = A_Base + row*N + k, o_Mem_Read=1.
REQ-020 RD_B: latch i_Mem_Rdata as a; address = B_Base + k*N + col, o_Mem_Read=1.
REQ-021 ACC: acc += a*i_Mem_Rdata, signed, with acc 2*DATA_W wide.
REQ-022 ACC: if k=N-1, go to WR; otherwise increment k and go to RD_A.
REQ-023 WR: address = C_Base + row*N + col, o_Mem_Write=1, o_Mem_Wdata = acc[DATA_W-1:0] (truncation); go to DONE.
REQ-024 DONE: pulse o_Result_Ready for one cycle; return to IDLE.
REQ-025 Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.
REQ-026 If i_Grant=0 in RD_A, RD_B, ACC or WR: stall; no strobe, no k/acc update; resume at the same step when the grant returns.
REQ-027 With continuous grant, latency from the o_Indexes_Received cycle to the o_Result_Ready cycle is 3N+3 cycles.
REQ-028 i_Indexes_Ready outside IDLE is ignored; no new pair is accepted until IDLE is re-entered.

Reset
REQ-029 i_Reset forces IDLE and zeroes k, acc, the latched indexes and every output, at any time including mid-transaction; no partial write completes.

Configuration
REQ-030 With PROCESSING_ELEMENT_SATURATE_EN defined, WR writes acc saturated to the signed DATA_W range; without it, WR writes the truncated low DATA_W bits.

Structure
REQ-031 The state encodings and default widths live in package coproc_pkg, shared with the main control unit.
REQ-032 The multiply-accumulate datapath (with optional saturation) is sub-module pe_mac; the FSM and address generation stay in processing_element.

Verification
REQ-033 N=2, A=[[1,2],[3,4]] at 0x00, B=[[5,6],[7,8]] at 0x10, C at 0x20, row=1 col=0, grant held -> write 43 to 0x22; o_Result_Ready 9 cycles after o_Indexes_Received.
REQ-034 Same as REQ-033 with i_Grant dropped for 3 cycles during RD_B -> same value and address; latency 12 cycles.
REQ-035 N=0 -> exactly one write of 0 to C_Base + 0; zero reads.
REQ-036 Elements 0x7FFFFFFF*2, N=1 -> 0xFFFFFFFE written without the macro; 0x7FFFFFFF written with it.
REQ-037 i_Reset asserted in ACC -> next cycle all outputs 0, state IDLE; a following pair completes correctly.
REQ-038 i_Indexes_Ready held high through a whole transaction -> exactly one o_Indexes_Received pulse per IDLE entry.
